// File: rtl/pwm_pkg.sv
// Shared definitions for the PCM-to-PWM converter: modulation mode encoding and
// the signed-sample to offset-binary duty conversion.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    // Keeps the top cw bits of a dw-bit two's-complement sample and flips the
    // sign bit, turning it into an unsigned offset-binary duty.
    function automatic logic [31:0] pcm2duty(input logic [31:0] sample,
                                             input int dw,
                                             input int cw);
        logic [31:0] d;
        d = (sample >> (dw - cw)) & ((32'd1 << cw) - 32'd1);
        d[cw-1] = ~d[cw-1];
        return d;
    endfunction

endpackage

// File: rtl/pcm_to_pwm_mc_if.sv
// Frame input handshake of the PCM-to-PWM converter; channel k lives in
// in_data[k*DW +: DW].
interface pcm_to_pwm_mc_if #(
    parameter int CH = 2,
    parameter int DW = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [CH*DW-1:0]  in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: active duty register and registered comparator against the
// shared count.
module pwm_chan #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cnt_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          pwm_o
);
    localparam logic [CW-1:0] DUTY_MID = {1'b1, {(CW-1){1'b0}}};

    logic [CW-1:0] a_q;
    logic [CW-1:0] a_d;
    logic          pwm_q;
    logic          pwm_d;

    always_comb begin
        a_d   = load_i ? load_val_i : a_q;
        pwm_d = (cnt_i < a_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= DUTY_MID;
            pwm_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/pcm_to_pwm_mc.sv
// Multi-channel PCM-to-PWM converter: shared phase counter, one-frame shadow
// buffer, period boundary control and per-channel comparators.
module pcm_to_pwm_mc
    import pwm_pkg::*;
#(
    parameter int CH = 2,
    parameter int DW = 16,
    parameter int CW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_i,
    pcm_to_pwm_mc_if.slave   pcm,
    output logic [CH-1:0]    pwm_out_o,
    output logic             period_start_o,
    output logic             underrun_o
);
    logic [CW:0]   p_q, p_d;
    logic          mode_act_q, mode_act_d;
    logic          shadow_full_q, shadow_full_d;
    logic [CW-1:0] shadow_q [CH];
    logic          ps_q, ps_d;
    logic          ur_q, ur_d;

    logic [CW-1:0] cnt;
    logic          wrap;
    logic          hs;
    logic          load;
    logic [CW-1:0] in_duty  [CH];
    logic [CW-1:0] load_val [CH];

    always_comb begin
        cnt  = p_q[CW-1:0];
        wrap = &p_q[CW-1:0];
        if (mode_act_q == MODE_CENTRE) begin
            cnt  = p_q[CW] ? ~p_q[CW-1:0] : p_q[CW-1:0];
            wrap = &p_q;
        end
    end

    assign pcm.in_ready = !shadow_full_q;
    assign hs           = pcm.in_valid && !shadow_full_q;
    // A frame arriving exactly on the boundary with an empty shadow goes straight to the channels.
    assign load         = wrap && (shadow_full_q || hs);

    always_comb begin
        p_d           = p_q + 1'b1;
        mode_act_d    = mode_act_q;
        shadow_full_d = shadow_full_q;
        ps_d          = wrap;
        ur_d          = wrap && !shadow_full_q && !hs;
        if (wrap) begin
            p_d           = '0;
            mode_act_d    = mode_i;
            shadow_full_d = 1'b0;
        end else if (hs) begin
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q           <= '0;
            mode_act_q    <= MODE_EDGE;
            shadow_full_q <= 1'b0;
            ps_q          <= 1'b0;
            ur_q          <= 1'b0;
            for (int k = 0; k < CH; k++) shadow_q[k] <= '0;
        end else begin
            p_q           <= p_d;
            mode_act_q    <= mode_act_d;
            shadow_full_q <= shadow_full_d;
            ps_q          <= ps_d;
            ur_q          <= ur_d;
            if (!wrap && hs) begin
                for (int k = 0; k < CH; k++) shadow_q[k] <= in_duty[k];
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_chan
        assign in_duty[k]  = CW'(pcm2duty(32'(pcm.in_data[k*DW +: DW]), DW, CW));
        assign load_val[k] = shadow_full_q ? shadow_q[k] : in_duty[k];

        pwm_chan #(.CW(CW)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .cnt_i      (cnt),
            .load_i     (load),
            .load_val_i (load_val[k]),
            .pwm_o      (pwm_out_o[k])
        );
    end

    assign period_start_o = ps_q;
    assign underrun_o     = ur_q;
endmodule

// File: doc/pcm_to_pwm_mc.md
Name: pcm_to_pwm_mc

Overview:
Multi-channel, parametrised PCM-to-PWM converter for the audio output path. It accepts signed PCM frames, one sample per channel, through a valid/ready handshake and converts each to offset-binary duty at CW-bit resolution. Each channel drives a glitch-free PWM pin, with duty updated only at period boundaries. Edge-aligned and centre-aligned modulation are runtime-selectable, and missed samples are reported as underrun.

Parameters:
CH, 2, number of channels
DW, 16, PCM sample width (signed, two's complement)
CW, 10, PWM resolution in bits (CW <= DW)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
mode  in  1  0 = edge-aligned, 1 = centre-aligned; sampled at period boundary only
in_valid  in  1  frame valid
in_ready  out  1  frame accepted when in_valid && in_ready
in_data  in  CH*DW  channel k in bits [k*DW +: DW]
pwm_out  out  CH  PWM outputs, registered
period_start  out  1  one-cycle pulse in the first cycle of each PWM period
underrun  out  1  one-cycle pulse when a period starts with no new frame available

Behaviour:
- Duty conversion: d_k = in_data_k[DW-1:DW-CW] with MSB inverted (offset binary). Examples for CW=10: -32768 -> 0, 0 -> 512, 32767 -> 1023.
- Phase counter p: CW+1 bits, incrementing every clk.
- Compare value cnt:
  - Edge mode: cnt = p[CW-1:0]; period = 2^CW cycles.
  - Centre mode: cnt = p[CW] ? ~p[CW-1:0] : p[CW-1:0]; period = 2^(CW+1) cycles (triangle with peak and trough each held 2 cycles).
- wrap (combinational):
  - Edge mode: p[CW-1:0] == all-ones.
  - Centre mode: p == all-ones.
- On wrap, all of the following happen in the same clk edge:
  - p <= 0
  - mode_act <= mode
  - Each active duty a_k loads from the shadow register if it is full. If the shadow is empty and a handshake occurs in the same cycle, in_data bypasses directly into a_k.
  - shadow_full <= 0
  - period_start <= 1
  - underrun <= !shadow_full && !(in_valid && in_ready)
  - If no new data is available, a_k holds its value.
- Outside wrap: period_start and underrun return to 0.
- Shadow buffer:
  - Holds one frame.
  - in_ready = !shadow_full (combinational).
  - A handshake while not in wrap loads the shadow and sets shadow_full.
  - A second frame is back-pressured until the next wrap.
- pwm_out_k <= (cnt < a_k), evaluated every cycle.
  - Latency: pwm_out reflects cnt one cycle later, so the first count of a period appears in the cycle after period_start.
  - High time per period: edge mode = d cycles; centre mode = 2d cycles, contiguous and centred on the trough-to-peak ramp pair.
  - d = 0 gives constant low. d = 2^CW-1 gives high for all but 1 (edge) or 2 (centre) cycles.
- A mode change mid-period has no effect until the next wrap. The current period completes in the old mode, which prevents runt pulses.
- Reset (asynchronous, immediate, including mid-period):
  - p = 0, mode_act = 0, shadow empty, a_k = 2^(CW-1) (midscale, 50%).
  - pwm_out = 0, period_start = 0, underrun = 0.
  - in_ready = 1 during and after reset.
  - The first wrap after release occurs 2^CW cycles later (edge mode).
- Widths: comparison is unsigned at CW bits. The low DW-CW sample bits are discarded (truncation, no dither).

Decomposition:
- Shared package pwm_pkg: mode constants MODE_EDGE/MODE_CENTRE, and function pcm2duty(signed sample) returning a CW-bit offset-binary duty.
- Sub-module pwm_chan, instantiated CH times: holds a_k and the registered comparator. Inputs: clk, rst_n, cnt, load, load_val. Output: pwm_out bit.
- Top level holds p, mode_act, shadow, handshake and status pulses.

Test Plan (CH=2, DW=16, CW=4 unless noted):
1. Reset release, no input, edge mode -> both pwm_out high 8 of every 16 cycles. period_start every 16 cycles. underrun pulses at every wrap.
2. Frame {ch0=0x8000, ch1=0x7FFF} accepted, edge mode -> from the next period, ch0 constant low and ch1 high 15 of 16 cycles. No underrun that period.
3. mode=1, ch0=0x0000 -> after the next wrap, period is 32 cycles with ch0 high 16 contiguous cycles. Toggling mode mid-period has no effect until the following wrap.
4. Two back-to-back frames -> first accepted; in_ready low until wrap; second accepted the cycle after wrap and applied at the following wrap.
5. Handshake coincident with wrap while the shadow is empty -> bypass into active duty in that same period; underrun stays 0.
6. rst_n asserted mid-period with pwm_out high -> pwm_out, period_start and underrun drop to 0 immediately (asynchronously); after release, duty is midscale.
